// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/bubble generation, D/E forwarding selects and mult/div
//               busy counter for the 5-stage MIPS pipeline.
//               Optional macro HAZ_PERF_EN adds a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic       D_is_md,
  input  logic [4:0] E_rs,
  input  logic [4:0] E_rt,
  input  logic [4:0] E_wreg,
  input  logic [1:0] E_tnew,
  input  logic       E_md_start,
  input  logic       E_md_div,
  input  logic [4:0] M_wreg,
  input  logic [1:0] M_tnew,
  input  logic [4:0] W_wreg,
  output logic       stall,
  output logic       clr_ER,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt,
`ifdef HAZ_PERF_EN
  output logic       md_busy,
  output logic [31:0] perf_stall_cnt
`else
  output logic       md_busy
`endif
);

  localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] r_md_cnt;

  logic w_e_d_rs, w_m_d_rs, w_w_d_rs;
  logic w_e_d_rt, w_m_d_rt, w_w_d_rt;
  logic w_m_e_rs, w_w_e_rs, w_m_e_rt, w_w_e_rt;
  logic w_stall_rs, w_stall_rt, w_md_stall, w_stall;
  logic w_md_busy;
  logic [1:0] w_fwd_d_rs, w_fwd_d_rt, w_fwd_e_rs, w_fwd_e_rt;

  // Register $0 is hard-wired zero, so it never matches a producer.
  assign w_e_d_rs = (D_rs != 5'd0) && (E_wreg == D_rs);
  assign w_m_d_rs = (D_rs != 5'd0) && (M_wreg == D_rs);
  assign w_w_d_rs = (D_rs != 5'd0) && (W_wreg == D_rs);
  assign w_e_d_rt = (D_rt != 5'd0) && (E_wreg == D_rt);
  assign w_m_d_rt = (D_rt != 5'd0) && (M_wreg == D_rt);
  assign w_w_d_rt = (D_rt != 5'd0) && (W_wreg == D_rt);
  assign w_m_e_rs = (E_rs != 5'd0) && (M_wreg == E_rs);
  assign w_w_e_rs = (E_rs != 5'd0) && (W_wreg == E_rs);
  assign w_m_e_rt = (E_rt != 5'd0) && (M_wreg == E_rt);
  assign w_w_e_rt = (E_rt != 5'd0) && (W_wreg == E_rt);

  assign w_stall_rs = (w_e_d_rs && (E_tnew > D_tuse_rs)) ||
                      (w_m_d_rs && (M_tnew > D_tuse_rs));
  assign w_stall_rt = (w_e_d_rt && (E_tnew > D_tuse_rt)) ||
                      (w_m_d_rt && (M_tnew > D_tuse_rt));

  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_stall = D_is_md && (w_md_busy || E_md_start);
  assign w_stall    = w_stall_rs || w_stall_rt || w_md_stall;

  always_comb begin
    w_fwd_d_rs = 2'd0;
    if (w_e_d_rs && (E_tnew == 2'd0))      w_fwd_d_rs = 2'd3;
    else if (w_m_d_rs && (M_tnew == 2'd0)) w_fwd_d_rs = 2'd2;
    else if (w_w_d_rs)                     w_fwd_d_rs = 2'd1;
  end

  always_comb begin
    w_fwd_d_rt = 2'd0;
    if (w_e_d_rt && (E_tnew == 2'd0))      w_fwd_d_rt = 2'd3;
    else if (w_m_d_rt && (M_tnew == 2'd0)) w_fwd_d_rt = 2'd2;
    else if (w_w_d_rt)                     w_fwd_d_rt = 2'd1;
  end

  always_comb begin
    w_fwd_e_rs = 2'd0;
    if (w_m_e_rs && (M_tnew == 2'd0)) w_fwd_e_rs = 2'd2;
    else if (w_w_e_rs)                w_fwd_e_rs = 2'd1;
  end

  always_comb begin
    w_fwd_e_rt = 2'd0;
    if (w_m_e_rt && (M_tnew == 2'd0)) w_fwd_e_rt = 2'd2;
    else if (w_w_e_rt)                w_fwd_e_rt = 2'd1;
  end

  // Starts arriving while busy are dropped; md_stall keeps them from occurring.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (E_md_start && (r_md_cnt == '0)) begin
      r_md_cnt <= E_md_div ? c_DIV_LOAD : c_MULT_LOAD;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  // Combinational outputs are masked while reset is held low.
  assign stall    = reset & w_stall;
  assign clr_ER   = reset & w_stall;
  assign fwd_D_rs = reset ? w_fwd_d_rs : 2'd0;
  assign fwd_D_rt = reset ? w_fwd_d_rt : 2'd0;
  assign fwd_E_rs = reset ? w_fwd_e_rs : 2'd0;
  assign fwd_E_rt = reset ? w_fwd_e_rt : 2'd0;
  assign md_busy  = w_md_busy;

`ifdef HAZ_PERF_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_cnt <= 32'd0;
    end else if (w_stall && (r_perf_cnt != 32'hFFFF_FFFF)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_rs, E_rt, E_wreg, M_wreg, W_wreg;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_is_md, E_md_start, E_md_div;
  logic       stall, clr_ER, md_busy;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_is_md    (D_is_md),
    .E_rs       (E_rs),
    .E_rt       (E_rt),
    .E_wreg     (E_wreg),
    .E_tnew     (E_tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .M_wreg     (M_wreg),
    .M_tnew     (M_tnew),
    .W_wreg     (W_wreg),
    .stall      (stall),
    .clr_ER     (clr_ER),
    .fwd_D_rs   (fwd_D_rs),
    .fwd_D_rt   (fwd_D_rt),
    .fwd_E_rs   (fwd_E_rs),
    .fwd_E_rt   (fwd_E_rt),
`ifdef HAZ_PERF_EN
    .md_busy    (md_busy),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .md_busy    (md_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 1'b0;
    E_rs = 5'd0; E_rt = 5'd0; E_wreg = 5'd0; E_tnew = 2'd0;
    E_md_start = 1'b0; E_md_div = 1'b0;
    M_wreg = 5'd0; M_tnew = 2'd0; W_wreg = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    E_wreg = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0;
    M_wreg = 5'd3; E_rs = 5'd3; D_is_md = 1'b1; E_md_start = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({stall, clr_ER, md_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: stall/clr/busy=%b expected 000", {stall, clr_ER, md_busy});
    end
    n_checks++;
    if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_fwd: fwd=%h expected 00", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt});
    end
    idle_inputs();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    idle_inputs();
    E_wreg = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
    @(negedge clk);
    n_checks++;
    if ({stall, clr_ER} !== 2'b11) begin
      n_fail++;
      $display("FAIL load_use_E: stall/clr=%b expected 11", {stall, clr_ER});
    end
    next_cycle();
    E_wreg = 5'd0; E_tnew = 2'd0; M_wreg = 5'd8; M_tnew = 2'd1; D_tuse_rs = 2'd0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_M_branch: stall=%b expected 1", stall);
    end
    next_cycle();
    M_wreg = 5'd0; M_tnew = 2'd0; W_wreg = 5'd8; D_tuse_rs = 2'd1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_D_rs !== 2'd1) begin
      n_fail++;
      $display("FAIL load_W_fwd: stall=%b fwd_D_rs=%0d expected 0/1", stall, fwd_D_rs);
    end
    // rt path with store-data tuse: load in E (tnew 2) does not exceed tuse 2
    idle_inputs();
    E_wreg = 5'd12; E_tnew = 2'd2; D_rt = 5'd12; D_tuse_rt = 2'd2;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rt_store_nostall: stall=%b expected 0", stall);
    end
    D_tuse_rt = 2'd1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || clr_ER !== 1'b1) begin
      n_fail++;
      $display("FAIL rt_alu_stall: stall=%b clr=%b expected 1/1", stall, clr_ER);
    end
    D_tuse_rt = 2'd3;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL tuse3_nostall: stall=%b expected 0", stall);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    E_wreg = 5'd0; E_tnew = 2'd2; D_rs = 5'd0; D_tuse_rs = 2'd0; W_wreg = 5'd0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_D_rs !== 2'd0) begin
      n_fail++;
      $display("FAIL zero_reg: stall=%b fwd_D_rs=%0d expected 0/0", stall, fwd_D_rs);
    end
    next_cycle();
  endtask

  task automatic test_priority();
    idle_inputs();
    E_wreg = 5'd9; M_wreg = 5'd9; W_wreg = 5'd9; E_tnew = 2'd0; M_tnew = 2'd0;
    D_rt = 5'd9; D_tuse_rt = 2'd2;
    @(negedge clk);
    n_checks++;
    if (fwd_D_rt !== 2'd3) begin
      n_fail++;
      $display("FAIL prio_E: fwd_D_rt=%0d expected 3", fwd_D_rt);
    end
    E_tnew = 2'd1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || fwd_D_rt !== 2'd2) begin
      n_fail++;
      $display("FAIL prio_M: stall=%b fwd_D_rt=%0d expected 0/2", stall, fwd_D_rt);
    end
    M_tnew = 2'd1;
    @(negedge clk);
    n_checks++;
    if (fwd_D_rt !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_W: fwd_D_rt=%0d expected 1", fwd_D_rt);
    end
    // E-stage selects
    E_rs = 5'd9; E_rt = 5'd4; M_tnew = 2'd0;
    @(negedge clk);
    n_checks++;
    if (fwd_E_rs !== 2'd2 || fwd_E_rt !== 2'd0) begin
      n_fail++;
      $display("FAIL fwdE_M: fwd_E_rs=%0d fwd_E_rt=%0d expected 2/0", fwd_E_rs, fwd_E_rt);
    end
    M_tnew = 2'd1; W_wreg = 5'd4; E_rt = 5'd4; E_rs = 5'd9;
    @(negedge clk);
    n_checks++;
    if (fwd_E_rs !== 2'd0 || fwd_E_rt !== 2'd1) begin
      n_fail++;
      $display("FAIL fwdE_W: fwd_E_rs=%0d fwd_E_rt=%0d expected 0/1", fwd_E_rs, fwd_E_rt);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_mult();
    idle_inputs();
    E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_t0: stall=%b md_busy=%b expected 1/0", stall, md_busy);
    end
    next_cycle();
    E_md_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL mult_busy_t%0d: stall=%b md_busy=%b expected 1/1", k, stall, md_busy);
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_done: stall=%b md_busy=%b expected 0/0", stall, md_busy);
    end
    // Start without an MD instruction in D does not stall
    D_is_md = 1'b0; E_md_start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL start_nomd: stall=%b expected 0", stall);
    end
    idle_inputs();
    for (int k = 0; k < 6; k++) next_cycle();
  endtask

  task automatic test_div_reset();
    idle_inputs();
    E_md_start = 1'b1; E_md_div = 1'b1;
    next_cycle();
    E_md_start = 1'b0; D_is_md = 1'b1;
    // count reads 10 now; after four more edges it reads 6
    for (int k = 0; k < 4; k++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (md_busy !== 1'b1 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL div_busy: md_busy=%b stall=%b expected 1/1", md_busy, stall);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL div_async_rst: md_busy=%b stall=%b expected 0/0", md_busy, stall);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_after_rst: stall=%b md_busy=%b expected 0/0", stall, md_busy);
    end
    // div runs 10 busy cycles: check the last busy and first idle cycle
    idle_inputs();
    E_md_start = 1'b1; E_md_div = 1'b1;
    next_cycle();
    E_md_start = 1'b0;
    for (int k = 1; k < 10; k++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (md_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL div_last_busy: md_busy=%b expected 1", md_busy);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_done: md_busy=%b expected 0", md_busy);
    end
    idle_inputs();
    next_cycle();
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    idle_inputs();
    do_reset();
    E_wreg = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
    for (int k = 0; k < 3; k++) next_cycle();
    idle_inputs();
    for (int k = 0; k < 2; k++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (perf_stall_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_count: perf_stall_cnt=%0d expected 3", perf_stall_cnt);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (perf_stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: perf_stall_cnt=%0d expected 0", perf_stall_cnt);
    end
    next_cycle();
    reset = 1'b1;
  endtask
`endif

  initial begin
    idle_inputs();
    do_reset();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_priority();
    test_mult();
    test_div_reset();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
